// File: rtl/rxr_to_noc_if.sv
// Avalon-ST style packet stream bundle.
// Receiver drives the source side, the NoC bridge sinks it.
interface rxr_to_noc_if #(
  parameter int DATA_WIDTH = 512
) ();
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  sop;
  logic                  eop;
  logic [5:0]            empty;

  modport sink (
    input  data, valid, sop, eop, empty,
    output ready
  );

  modport source (
    output data, valid, sop, eop, empty,
    input  ready
  );
endinterface

// File: rtl/rxr_to_noc.sv
// Receiver packet stream to NoC flit bridge.
// Header goes to the parser, payload beats to DDR, via a 2-entry skid.
module rxr_to_noc #(
  parameter int         DATA_WIDTH  = 512,
  parameter int         NOC_WIDTH   = 600,
  parameter int         NUM_VC      = 2,
  parameter int         NOC_RADIX   = 16,
  parameter int         NODE_ID     = 0,
  parameter logic [3:0] PARSER_PORT = 4'd15,
  parameter logic [3:0] DDR_PORT    = 4'd4,
  parameter int         MAX_BEATS   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  rxr_to_noc_if.sink           in,
  output logic [NOC_WIDTH-1:0] o_data_out,
  output logic                 o_valid_out,
  input  logic                 o_ready_in,
  output logic [31:0]          o_pkt_count,
  output logic [15:0]          o_drop_count
);

  localparam int VW     = $clog2(NUM_VC);
  localparam int RW     = $clog2(NOC_RADIX);
  localparam int CW     = $clog2(MAX_BEATS + 1);
  localparam int E_LO   = DATA_WIDTH;
  localparam int SOP_B  = E_LO + 6;
  localparam int EOP_B  = SOP_B + 1;
  localparam int PF_B   = EOP_B + 1;
  localparam int ID_LO  = PF_B + 1;
  localparam int IX_LO  = ID_LO + 32;
  localparam int ND_LO  = IX_LO + 6;
  localparam int DST_LO = NOC_WIDTH - RW;
  localparam int VC_LO  = DST_LO - VW;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PAYLOAD = 2'd1;
  localparam logic [1:0] DROP    = 2'd2;

  logic [1:0]           state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [31:0]          pkt_id, id_n, pkt_n, flit_id;
  logic                 live;
  logic [NOC_WIDTH-1:0] mem [2];
  logic                 wr, rd;
  logic [1:0]           fill;
  logic                 acc, push, pop;
  logic                 hdr, done, drop_ev;
  logic [NOC_WIDTH-1:0] flit;

  assign in.ready    = live && (fill != 2'd2);
  assign acc         = in.valid && in.ready;
  assign o_valid_out = (fill != 2'd0);
  assign o_data_out  = mem[rd];
  assign pop         = o_valid_out && o_ready_in;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    id_n    = pkt_id;
    pkt_n   = o_pkt_count;
    flit_id = pkt_id;
    hdr     = 1'b0;
    push    = 1'b0;
    done    = 1'b0;
    drop_ev = 1'b0;
    if (acc) begin
      if (in.sop) begin
        // a new sop closes any open packet without completing it
        if (state != IDLE) begin
          drop_ev = 1'b1;
          id_n    = pkt_id + 32'd1;
        end
        flit_id = id_n;
        hdr     = 1'b1;
        push    = 1'b1;
        state_n = PAYLOAD;
        cnt_n   = '0;
        done    = in.eop;
      end else begin
        unique case (1'b1)
          (state == IDLE): drop_ev = 1'b1;
          (state == PAYLOAD): begin
            if (cnt == CW'(MAX_BEATS)) begin
              drop_ev = 1'b1;
              state_n = DROP;
            end else begin
              push  = 1'b1;
              cnt_n = cnt + 1'b1;
            end
            done = in.eop;
          end
          (state == DROP): done = in.eop;
          default: state_n = IDLE;
        endcase
      end
    end
    if (done) begin
      id_n    = id_n + 32'd1;
      pkt_n   = o_pkt_count + 32'd1;
      state_n = IDLE;
    end
  end

  always_comb begin
    flit                 = '0;
    flit[E_LO-1:0]       = in.data;
    flit[E_LO +: 6]      = in.empty;
    flit[SOP_B]          = in.sop;
    flit[EOP_B]          = in.eop;
    flit[PF_B]           = hdr ? !in.eop : 1'b1;
    flit[ID_LO +: 32]    = flit_id;
    flit[IX_LO +: 6]     = hdr ? 6'd0 : 6'(cnt);
    flit[ND_LO +: RW]    = RW'(NODE_ID);
    flit[VC_LO +: VW]    = hdr ? '0 : VW'(1);
    flit[DST_LO +: RW]   = hdr ? RW'(PARSER_PORT)
                               : RW'(DDR_PORT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      pkt_id       <= '0;
      o_pkt_count  <= '0;
      o_drop_count <= '0;
      live         <= 1'b0;
      wr           <= 1'b0;
      rd           <= 1'b0;
      fill         <= '0;
      mem[0]       <= '0;
      mem[1]       <= '0;
    end else begin
      live        <= 1'b1;
      state       <= state_n;
      cnt         <= cnt_n;
      pkt_id      <= id_n;
      o_pkt_count <= pkt_n;
      if (drop_ev && o_drop_count != 16'hFFFF)
        o_drop_count <= o_drop_count + 16'd1;
      if (push) begin
        mem[wr] <= flit;
        wr      <= ~wr;
      end
      if (pop)
        rd <= ~rd;
      fill <= fill + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: doc/rxr_to_noc.md
RXR_TO_NOC -- requirements
Module: rxr_to_noc

Interface
REQ-001 SHALL have parameters: DATA_WIDTH 512 (stream data bits); NOC_WIDTH 600 (flit bits); NUM_VC 2 (NoC VCs); NOC_RADIX 16 (NoC nodes); NODE_ID 0 (own node, source field); PARSER_PORT 4'd15 (header destination); DDR_PORT 4'd4 (payload destination); MAX_BEATS 32 (max payload beats per packet).
REQ-002 SHALL have ports: clk  input  1  sole clock; reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have: in  avalonST sink  DATA_WIDTH  packet stream from receiver (data, valid, ready, sop, eop, empty[5:0]).
REQ-004 SHALL have: o_data_out  output  NOC_WIDTH  flit to NoC; o_valid_out  output  1  flit valid; o_ready_in  input  1  NoC accepts flit.
REQ-005 SHALL have: o_pkt_count  output  32  completed packets; o_drop_count  output  16  malformed or oversize events.

Function
REQ-006 Flit layout SHALL be: [511:0] data, [517:512] empty, [518] sop, [519] eop, [520] payload_flag, [552:521] pkt_id, [558:553] beat index, [562:559] NODE_ID, [594:563] zero, [595] vc, [599:596] dst.
REQ-007 Input beat accepted iff in.valid && in.ready; in.ready SHALL be high iff the 2-entry output skid buffer has a free entry, giving a full-rate stream without combinational ready path from o_ready_in.
REQ-008 Output SHALL hold o_data_out stable while o_valid_out && !o_ready_in; entries leave in order; latency accept -> o_valid_out is 1 cycle when buffer empty.
REQ-009 FSM states SHALL be IDLE, PAYLOAD, DROP.
REQ-010 IDLE, accepted beat with sop: emit header flit, dst PARSER_PORT, vc 0, beat index 0, payload_flag = !eop; if eop stay IDLE and complete packet, else go PAYLOAD with beat counter 0.
REQ-011 IDLE, accepted beat without sop: discard, o_drop_count +1, stay IDLE.
REQ-012 PAYLOAD, accepted beat without sop: emit flit, dst DDR_PORT, vc 1, payload_flag 1, beat index = counter, counter +1; on eop complete packet, go IDLE.
REQ-013 PAYLOAD, payload beat when counter == MAX_BEATS (and no eop): discard, o_drop_count +1, go DROP; if that beat carries eop, discard it, count drop, complete packet, go IDLE.
REQ-014 DROP: discard all beats until eop; on eop complete packet, go IDLE; sop in DROP treated per REQ-015.
REQ-015 PAYLOAD or DROP, accepted beat with sop: previous packet terminated (o_drop_count +1, pkt_id +1, o_pkt_count unchanged), beat handled as IDLE sop in the same cycle.
REQ-016 Packet completion SHALL increment pkt_id and o_pkt_count by 1; both wrap 2^32-1 -> 0; o_drop_count saturates at 16'hFFFF.
REQ-017 pkt_id in a flit SHALL be the id of its packet; header and all payload flits share it.
REQ-018 Discarded beats SHALL still be accepted (ready per REQ-007) and produce no flit.

Reset
REQ-019 reset low SHALL asynchronously clear: FSM to IDLE, beat counter, pkt_id, o_pkt_count, o_drop_count to 0, skid buffer emptied, o_valid_out 0, o_data_out 0, in.ready 0 while asserted.
REQ-020 After reset release, in.ready SHALL be 1 from the first clk edge; reset mid-packet SHALL discard buffered flits, and the partial packet SHALL NOT resume.

Verification
REQ-021 3-beat packet (sop, mid, eop), o_ready_in 1 -> flits: dst 15 vc 0 pf 1 id 0; dst 4 vc 1 idx 0; dst 4 idx 1 eop; o_pkt_count 1.
REQ-022 Single beat sop&eop -> one flit dst 15, pf 0, eop 1; next packet uses pkt_id 1.
REQ-023 o_ready_in low 5 cycles during streaming -> in.ready drops after 2 buffered flits, no flit lost or reordered, o_data_out stable.
REQ-024 Header + 34 payload beats (MAX_BEATS 32) -> 32 DDR flits idx 0..31, rest discarded, o_drop_count 1, o_pkt_count 1.
REQ-025 sop mid-packet, then stray non-sop beat in IDLE -> o_drop_count 2, new packet id = old id + 1.
REQ-026 reset low during packet -> o_valid_out 0, counters 0; next packet header carries pkt_id 0.
